// File: rtl/modulus_counter_pkg.sv
// Shared constants and helpers for the modulus_counter timebase.
// Optional feature macro: MODULUS_COUNTER_WRAP_CNT_EN (adds the wrap counter).
package modulus_counter_pkg;

  localparam int DEFAULT_WIDTH   = 6;
  localparam int DEFAULT_MODULUS = 60;

  // Width of the optional saturating wrap counter.
  localparam int WRAP_CNT_W = 16;

  // Smallest register width able to hold MODULUS distinct states.
  function automatic int clog2_min(input int modulus);
    int w;
    w = 0;
    while ((w < 31) && ((32'sd1 <<< w) < modulus)) begin
      w++;
    end
    return w;
  endfunction

endpackage : modulus_counter_pkg

// File: rtl/modulus_counter_if.sv
// Output bundle of modulus_counter for consumers of the timebase.
// The master side is the counter; the slave side is any block reading it.
// Optional feature macro: MODULUS_COUNTER_WRAP_CNT_EN (adds wrap_cnt).
interface modulus_counter_if
  import modulus_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] count;
  logic             tc;

`ifdef MODULUS_COUNTER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  modport master (output count, output tc, output wrap_cnt);
  modport slave  (input  count, input  tc, input  wrap_cnt);
`else
  modport master (output count, output tc);
  modport slave  (input  count, input  tc);
`endif

endinterface : modulus_counter_if

// File: rtl/modulus_counter.sv
// Free-running modulo-MODULUS up-counter (default mod-60, 6 bits) with a
// combinational terminal-count flag. Driven only by clk and an asynchronous
// active-low reset. Any out-of-range count recovers to 0 on the next edge.
// Optional feature macro: MODULUS_COUNTER_WRAP_CNT_EN adds a 16-bit
// saturating count of MODULUS-1 -> 0 wraps since reset.
module modulus_counter
  import modulus_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WIDTH-1:0]      count,
  output logic                  tc
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

  // Reject configurations whose state space does not fit the register.
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH)) || (WIDTH < clog2_min(MODULUS))) begin : g_param_check
    $fatal(1, "modulus_counter: illegal MODULUS=%0d for WIDTH=%0d", MODULUS, WIDTH);
  end

  // Last legal count, held one bit wider so MODULUS == 2**WIDTH still fits.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   count_inc;
  logic [WIDTH-1:0] count_d;

  // Next-state: increment WIDTH+1 wide, wrap (or recover) to 0 at/above LAST.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    count_ext = {1'b0, count};
    count_inc = count_ext + {{WIDTH{1'b0}}, 1'b1};
    count_d   = count_inc[WIDTH-1:0];
    // >= rather than == so an upset into an illegal state self-clears; the
    // carry term is redundant for legal states but never lets a wrapped-around
    // sum through.
    if ((count_ext >= LAST) || count_inc[WIDTH]) begin
      count_d = '0;
    end
  end

  // Count register; reset clears it immediately without a clock.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  // Terminal count decode: high for the single cycle spent at MODULUS-1.
  assign tc = (count_ext == LAST);

`ifdef MODULUS_COUNTER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_q;

  // Wrap tracker: tc marks the cycle whose closing edge wraps to 0; saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= '0;
    end else if (tc && (wrap_q != {WRAP_CNT_W{1'b1}})) begin
      wrap_q <= wrap_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule : modulus_counter

// File: tb/tb_modulus_counter.sv
// Bench for modulus_counter: a mod-60 (default) and a mod-64 instance run
// side by side. Each rising edge pushes the expected outputs, derived from the
// number of edges since reset release, into a queue; a monitor pops and
// compares on every falling edge. Reset pulses are applied between edges.
// Honours MODULUS_COUNTER_WRAP_CNT_EN when the design is built with it.
module tb_modulus_counter;
  import modulus_counter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  modulus_counter_if #(.WIDTH(6)) bus60 ();
  modulus_counter_if #(.WIDTH(6)) bus64 ();

  modulus_counter dut60 (
    .clk      (clk),
    .rst      (rst),
    .count    (bus60.count),
    .tc       (bus60.tc)
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt (bus60.wrap_cnt)
`endif
  );

  modulus_counter #(.WIDTH(6), .MODULUS(64)) dut64 (
    .clk      (clk),
    .rst      (rst),
    .count    (bus64.count),
    .tc       (bus64.tc)
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt (bus64.wrap_cnt)
`endif
  );

  typedef struct {
    int c60;
    int c64;
    int w60;
    int w64;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;  // rising edges seen with reset released

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the counter is simply (edges since release) mod MODULUS, and
  // completed wraps are the integer quotient, capped at 16 bits.
  function automatic exp_t model(input int edges);
    exp_t e;
    e.c60 = edges % 60;
    e.c64 = edges % 64;
    e.w60 = (edges / 60 > 65535) ? 65535 : edges / 60;
    e.w64 = (edges / 64 > 65535) ? 65535 : edges / 64;
    return e;
  endfunction

  // One rising edge: advance the model and queue what the DUT must show.
  task automatic tick();
    @(posedge clk);
    if (rst) n++;
    else     n = 0;
    sb.push_back(model(n));
  endtask

  // Change reset between edges; on assertion confirm the asynchronous clear.
  task automatic set_rst(input logic v);
    @(negedge clk);
    #1;
    rst = v;
    if (!v) begin
      n = 0;
      #1;
      check("async_clr_count60", int'(bus60.count), 0);
      check("async_clr_tc60",   int'(bus60.tc),    0);
      check("async_clr_count64", int'(bus64.count), 0);
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
      check("async_clr_wrap60", int'(bus60.wrap_cnt), 0);
`endif
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("count60", int'(bus60.count), e.c60);
      check("tc60",    int'(bus60.tc),    (e.c60 == 59) ? 1 : 0);
      check("count64", int'(bus64.count), e.c64);
      check("tc64",    int'(bus64.tc),    (e.c64 == 63) ? 1 : 0);
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
      check("wrap60",  int'(bus60.wrap_cnt), e.w60);
      check("wrap64",  int'(bus64.wrap_cnt), e.w64);
`endif
    end
  end

  initial begin
    int guard;

    // Reset asserted before any clock edge must clear the outputs on its own.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("reset_count60", int'(bus60.count), 0);
    check("reset_tc60",    int'(bus60.tc),    0);

    // Edge at 5 ns with reset held, release at 10 ns.
    tick();
    #5;
    rst = 1'b1;

    // 50 edges: count walks 1..50 with tc quiet.
    repeat (50) tick();
    @(negedge clk);
    check("count_after_50", int'(bus60.count), 50);

    // Three full mod-60 periods plus change; mod-64 wraps twice on the way.
    repeat (135) tick();
`ifdef MODULUS_COUNTER_WRAP_CNT_EN
    @(negedge clk);
    check("wrap_after_185", int'(bus60.wrap_cnt), 3);
`endif

    // Advance to count 37, then reset between edges.
    guard = 0;
    while (((n % 60) != 37) && (guard < 100)) begin
      tick();
      guard++;
    end
    check("reached_37", n % 60, 37);
    @(negedge clk);
    check("pre_reset_count60", int'(bus60.count), 37);
    set_rst(1'b0);
    tick();
    set_rst(1'b1);
    tick();  // first edge after release must give 1

    // Random run with occasional asynchronous reset pulses.
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        set_rst(1'b0);
        repeat ($urandom_range(1, 3)) tick();
        set_rst(1'b1);
      end
      tick();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_modulus_counter
